// File: rtl/radar_pri_gen.sv
// Radar transmit-gate generator: programmable pulse width, staggered PRI
// rotation over a table of up to N_STAG intervals, and finite or continuous
// bursts. All live configuration is shadowed and only adopted at a PRI
// boundary, so register writes never cut a pulse short or stretch a PRI.
module radar_pri_gen #(
  parameter  int CNT_W   = 16,
  parameter  int N_STAG  = 4,
  parameter  int BURST_W = 8,
  localparam int SL_W    = $clog2(N_STAG + 1),
  localparam int IDX_W   = $clog2(N_STAG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [CNT_W-1:0]        pw,
  input  logic [N_STAG*CNT_W-1:0] pri_tbl,
  input  logic [SL_W-1:0]         stag_len,
  input  logic [BURST_W-1:0]      burst_len,
  output logic                    pulse_out,
  output logic                    pri_start,
  output logic [IDX_W-1:0]        stag_idx,
  output logic                    burst_done,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A PRI shorter than 2 cycles cannot hold both a high and a low cycle.
  function automatic logic [CNT_W-1:0] clamp_pri(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // Guarantee at least one low cycle per PRI.
  function automatic logic [CNT_W-1:0] clamp_pw(input logic [CNT_W-1:0] w,
                                                input logic [CNT_W-1:0] p);
    return (w >= p) ? (p - CNT_W'(1)) : w;
  endfunction

  // Rotation length is forced into 1..N_STAG.
  function automatic logic [SL_W-1:0] clamp_sl(input logic [SL_W-1:0] s);
    if (s == '0)               return SL_W'(1);
    else if (s > SL_W'(N_STAG)) return SL_W'(N_STAG);
    else                       return s;
  endfunction

  // Registered state and active (shadowed) configuration
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [BURST_W-1:0]   bcnt;
  logic                 en_d;
  logic                 armed;        // en has been seen low since reset
  logic [CNT_W-1:0]     pw_act;
  logic [CNT_W-1:0]     pri_act;
  logic [BURST_W-1:0]   burst_len_act;

  // Next-state values
  state_t               nxt_state;
  logic [CNT_W-1:0]     nxt_cnt;
  logic [IDX_W-1:0]     nxt_idx;
  logic [BURST_W-1:0]   nxt_bcnt;
  logic [CNT_W-1:0]     nxt_pw;
  logic [CNT_W-1:0]     nxt_pri;
  logic [BURST_W-1:0]   nxt_burst_len;

  // Helpers
  logic [CNT_W-1:0]     tbl [N_STAG];
  logic [SL_W-1:0]      sl_cap;
  logic [SL_W-1:0]      idx_inc;
  logic [IDX_W-1:0]     idx_adv;
  logic [BURST_W-1:0]   bcnt_inc;
  logic [CNT_W-1:0]     pri_first;
  logic [CNT_W-1:0]     pri_next;
  logic                 start;
  logic                 pri_last;

  // Unpack the flat PRI table into addressable entries.
  always_comb begin
    for (int k = 0; k < N_STAG; k++) begin
      tbl[k] = pri_tbl[k*CNT_W +: CNT_W];
    end
  end

  // Boundary arithmetic: next stagger index, next PRI, completed-PRI count.
  always_comb begin
    sl_cap    = clamp_sl(stag_len);
    idx_inc   = SL_W'(idx) + SL_W'(1);
    // A shrunken rotation that no longer contains idx+1 restarts at entry 0.
    idx_adv   = (idx_inc < sl_cap) ? IDX_W'(idx_inc) : '0;
    bcnt_inc  = bcnt + BURST_W'(1);
    pri_first = clamp_pri(tbl[0]);
    pri_next  = clamp_pri(tbl[idx_adv]);
    // A held-high en after reset is not a start request; it must drop first.
    start     = en && !en_d && armed;
    pri_last  = (cnt == pri_act - CNT_W'(1));
  end

  // FSM next-state and shadow-register capture.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_idx       = idx;
    nxt_bcnt      = bcnt;
    nxt_pw        = pw_act;
    nxt_pri       = pri_act;
    nxt_burst_len = burst_len_act;

    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_state     = RUN;
          nxt_cnt       = '0;
          nxt_idx       = '0;
          nxt_bcnt      = '0;
          nxt_pri       = pri_first;
          nxt_pw        = clamp_pw(pw, pri_first);
          nxt_burst_len = burst_len;
        end
      end
      RUN: begin
        if (pri_last) begin
          nxt_cnt  = '0;
          nxt_bcnt = bcnt_inc;
          // Burst end takes priority over a graceful stop.
          if ((burst_len_act != '0) && (bcnt_inc == burst_len_act)) begin
            nxt_state = DONE;
          end else if (!en) begin
            nxt_state = IDLE;
          end else begin
            nxt_idx = idx_adv;
            nxt_pri = pri_next;
            nxt_pw  = clamp_pw(pw, pri_next);
          end
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State, shadow registers and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      bcnt          <= '0;
      en_d          <= 1'b0;
      armed         <= 1'b0;
      pw_act        <= '0;
      pri_act       <= '0;
      burst_len_act <= '0;
      pulse_out     <= 1'b0;
      pri_start     <= 1'b0;
      stag_idx      <= '0;
      burst_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      idx           <= nxt_idx;
      bcnt          <= nxt_bcnt;
      en_d          <= en;
      if (!en) armed <= 1'b1;
      pw_act        <= nxt_pw;
      pri_act       <= nxt_pri;
      burst_len_act <= nxt_burst_len;
      pulse_out     <= (nxt_state == RUN) && (nxt_cnt < nxt_pw);
      pri_start     <= (nxt_state == RUN) && (nxt_cnt == '0);
      stag_idx      <= nxt_idx;
      burst_done    <= (nxt_state == DONE);
      busy          <= (nxt_state == RUN);
    end
  end

endmodule
